if_stage: RTL and testbench
===========================

IF_STAGE -- requirements
Module: if_stage

Interface
- REQ-001 Parameter RESET_PC, default 16'h0000, is the PC value loaded on reset.
- REQ-002 Parameter NOP_WORD, default 16'h0000, is the instruction word driven into IF/ID for a bubble.
- REQ-003 Parameter HALT_WORD, default 16'hFFFF, is the fetched word that halts fetch.
- REQ-004 Port clk, input, 1 bit: the single clock; all state SHALL update on its rising edge.
- REQ-005 Port rst, input, 1 bit: reset, synchronous and active-high.
- REQ-006 Port im_addr, output, 16 bits: word address to instruction memory (IM data_in).
- REQ-007 Port im_data, input, 16 bits: instruction word returned by instruction memory (IM data_out).
- REQ-008 Port stall, input, 1 bit: when high, holds the PC and IF/ID.
- REQ-009 Port redirect, input, 1 bit: branch/jump taken; also flushes IF/ID.
- REQ-010 Port redirect_pc, input, 16 bits: target word address used when redirect is high.
- REQ-011 Port ifid_instr, output, 16 bits: registered instruction.
- REQ-012 Port ifid_pc1, output, 16 bits: registered address of the fetched word plus 1.
- REQ-013 Port ifid_valid, output, 1 bit: IF/ID holds a real instruction.
- REQ-014 Port halted, output, 1 bit: fetch is stopped on HALT_WORD.
- REQ-015 Port fetch_count, output, 16 bits: count of instructions accepted into IF/ID.

Function
- REQ-016 im_addr SHALL equal the pc register combinationally; memory read is combinational, so im_data for pc is valid in the same cycle.
- REQ-017 The FSM SHALL have exactly two states, RUN and HALTED; halted SHALL be 1 only in HALTED.
- REQ-018 Per-edge priority SHALL be rst, then redirect, then stall, then normal fetch.
- REQ-019 On redirect, in either state: pc <= redirect_pc; ifid_instr <= NOP_WORD; ifid_valid <= 0; state <= RUN; fetch_count is unchanged; stall is ignored.
- REQ-020 On stall in RUN without redirect: pc, IF/ID, state and fetch_count SHALL hold.
- REQ-021 Normal fetch in RUN: ifid_instr <= im_data; ifid_pc1 <= pc+1 (mod 2^16); ifid_valid <= 1; fetch_count increments.
- REQ-022 Normal fetch with im_data != HALT_WORD SHALL set pc <= pc+1; pc SHALL wrap from 16'hFFFF to 16'h0000.
- REQ-023 Normal fetch with im_data == HALT_WORD SHALL leave pc unchanged, capture the HALT word in IF/ID with valid=1, and set state <= HALTED.
- REQ-024 In HALTED without redirect: pc holds; ifid_instr <= NOP_WORD; ifid_valid <= 0; fetch_count holds; stall has no effect.
- REQ-025 fetch_count SHALL saturate at 16'hFFFF and never wrap.
- REQ-026 Fetch latency SHALL be one cycle: the word at address A is presented on ifid_instr in the cycle after im_addr==A is accepted.

Reset
- REQ-027 While rst is high at a clock edge: pc <= RESET_PC; ifid_instr <= NOP_WORD; ifid_pc1 <= 0; ifid_valid <= 0; fetch_count <= 0; state <= RUN.
- REQ-028 rst SHALL override simultaneous redirect and stall.
- REQ-029 Reset asserted mid-stall or in HALTED SHALL take effect on the same edge.
- REQ-030 Outputs SHALL be unknown-free from the first edge with rst high.

Verification
- REQ-031 Sequential fetch, memory[i]=i+16'h0100, no stall, 5 cycles after reset: im_addr steps 0,1,2,3,4; ifid_instr is 0100,0101,0102,0103 one cycle later; ifid_pc1 is 1,2,3,4; fetch_count=5.
- REQ-032 Stall high for 3 cycles at pc=2: im_addr stays 2 and IF/ID holds for 3 cycles; fetch then resumes with 0102.
- REQ-033 redirect=1, redirect_pc=16'h0040, with stall=1 on the same edge: next cycle pc=0040, ifid_valid=0, ifid_instr=0000; the following cycle ifid_instr=memory[0x40].
- REQ-034 memory[3]=FFFF: after it is fetched, halted=1, im_addr stays 3, ifid_valid pulses 1 once with FFFF, then stays 0; a later redirect to 0 clears halted and fetch restarts at 0.
- REQ-035 pc preset 16'hFFFF via redirect: the next normal fetch gives pc=0000 and ifid_pc1=0000.
- REQ-036 rst asserted in HALTED with redirect=1 on the same edge: pc=RESET_PC, halted=0, fetch_count=0, ifid_valid=0.

Source files
------------

// File: rtl/if_stage.sv
// Instruction fetch stage: PC register, IF/ID pipeline register and RUN/HALTED control.
// Instruction memory is read combinationally, so im_data for the current pc is valid in the same cycle.
module if_stage #(
    parameter logic [15:0] RESET_PC  = 16'h0000,
    parameter logic [15:0] NOP_WORD  = 16'h0000,
    parameter logic [15:0] HALT_WORD = 16'hFFFF
) (
    input  logic        clk,
    input  logic        rst,
    output logic [15:0] im_addr,
    input  logic [15:0] im_data,
    input  logic        stall,
    input  logic        redirect,
    input  logic [15:0] redirect_pc,
    output logic [15:0] ifid_instr,
    output logic [15:0] ifid_pc1,
    output logic        ifid_valid,
    output logic        halted,
    output logic [15:0] fetch_count
);

    typedef enum logic {
        RUN    = 1'b0,
        HALTED = 1'b1
    } state_e;

    state_e      state_q;
    logic [15:0] pc_q;
    logic [15:0] instr_q;
    logic [15:0] pc1_q;
    logic        valid_q;
    logic [15:0] cnt_q;

    logic [15:0] pc_d;
    logic [15:0] cnt_d;
    logic        is_halt;

    assign pc_d    = pc_q + 16'd1;
    assign cnt_d   = (cnt_q == 16'hFFFF) ? cnt_q : cnt_q + 16'd1;
    assign is_halt = (im_data == HALT_WORD);

    // Priority: reset, redirect, halted bubble, stall, normal fetch.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= RUN;
            pc_q    <= RESET_PC;
            instr_q <= NOP_WORD;
            pc1_q   <= 16'h0000;
            valid_q <= 1'b0;
            cnt_q   <= 16'h0000;
        end else if (redirect) begin
            state_q <= RUN;
            pc_q    <= redirect_pc;
            instr_q <= NOP_WORD;
            valid_q <= 1'b0;
        end else if (state_q == HALTED) begin
            instr_q <= NOP_WORD;
            valid_q <= 1'b0;
        end else if (!stall) begin
            instr_q <= im_data;
            pc1_q   <= pc_d;
            valid_q <= 1'b1;
            cnt_q   <= cnt_d;
            if (is_halt) begin
                state_q <= HALTED;
            end else begin
                pc_q <= pc_d;
            end
        end
    end

    assign im_addr     = pc_q;
    assign ifid_instr  = instr_q;
    assign ifid_pc1    = pc1_q;
    assign ifid_valid  = valid_q;
    assign halted      = (state_q == HALTED);
    assign fetch_count = cnt_q;

endmodule

// File: tb/tb_if_stage.sv
// Directed bench for if_stage: a reference model pushes expected state per edge
// onto a scoreboard queue, popped and compared one time unit after the edge.
module tb_if_stage;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [15:0] im_addr;
    logic [15:0] im_data;
    logic        stall = 1'b0;
    logic        redirect = 1'b0;
    logic [15:0] redirect_pc = 16'h0000;
    logic [15:0] ifid_instr;
    logic [15:0] ifid_pc1;
    logic        ifid_valid;
    logic        halted;
    logic [15:0] fetch_count;

    logic [15:0] mem [0:65535];

    int total = 0;
    int bad   = 0;

    typedef struct packed {
        logic [15:0] pc;
        logic [15:0] instr;
        logic [15:0] pc1;
        logic        valid;
        logic        halt;
        logic [15:0] cnt;
    } exp_t;

    exp_t sb [$];
    exp_t m;

    always #5 clk = ~clk;

    assign im_data = mem[im_addr];

    if_stage #(
        .RESET_PC (16'h0000),
        .NOP_WORD (16'h0000),
        .HALT_WORD(16'hFFFF)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .im_addr    (im_addr),
        .im_data    (im_data),
        .stall      (stall),
        .redirect   (redirect),
        .redirect_pc(redirect_pc),
        .ifid_instr (ifid_instr),
        .ifid_pc1   (ifid_pc1),
        .ifid_valid (ifid_valid),
        .halted     (halted),
        .fetch_count(fetch_count)
    );

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // One clock edge: model next state, push, drive, wait, pop and compare.
    task automatic step(input logic r, input logic s, input logic rd, input logic [15:0] rpc);
        exp_t  n;
        exp_t  e;
        logic [15:0] w;
        n = m;
        w = mem[m.pc];
        if (r) begin
            n.pc = 16'h0000; n.instr = 16'h0000; n.pc1 = 16'h0000;
            n.valid = 1'b0; n.halt = 1'b0; n.cnt = 16'h0000;
        end else if (rd) begin
            n.pc = rpc; n.instr = 16'h0000; n.valid = 1'b0; n.halt = 1'b0;
        end else if (m.halt) begin
            n.instr = 16'h0000; n.valid = 1'b0;
        end else if (!s) begin
            n.instr = w;
            n.pc1   = m.pc + 16'd1;
            n.valid = 1'b1;
            if (m.cnt != 16'hFFFF) n.cnt = m.cnt + 16'd1;
            if (w == 16'hFFFF) n.halt = 1'b1;
            else n.pc = m.pc + 16'd1;
        end
        sb.push_back(n);
        m = n;
        rst = r; stall = s; redirect = rd; redirect_pc = rpc;
        @(posedge clk);
        #1;
        e = sb.pop_front();
        chk("im_addr", im_addr, e.pc);
        chk("ifid_instr", ifid_instr, e.instr);
        chk("ifid_pc1", ifid_pc1, e.pc1);
        chk("ifid_valid", {15'd0, ifid_valid}, {15'd0, e.valid});
        chk("halted", {15'd0, halted}, {15'd0, e.halt});
        chk("fetch_count", fetch_count, e.cnt);
    endtask

    task automatic fetch(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 1'b0, 1'b0, 16'h0000);
    endtask

    initial begin
        for (int i = 0; i < 65536; i++) mem[i] = 16'(i + 16'h0100);
        mem[16'hFEFF] = 16'h1234;
        m = '0;
        @(posedge clk);
        #1;

        // Reset, including with stall and redirect asserted together
        step(1'b1, 1'b0, 1'b0, 16'h0000);
        step(1'b1, 1'b1, 1'b1, 16'h0040);
        chk("rst_pc", im_addr, 16'h0000);
        chk("rst_valid", {15'd0, ifid_valid}, 16'h0000);

        // Sequential fetch
        fetch(5);
        chk("seq_count", fetch_count, 16'd5);
        chk("seq_last_instr", ifid_instr, 16'h0104);
        chk("seq_pc1", ifid_pc1, 16'h0005);

        // Stall for three cycles at pc=2
        step(1'b1, 1'b0, 1'b0, 16'h0000);
        fetch(2);
        for (int i = 0; i < 3; i++) step(1'b0, 1'b1, 1'b0, 16'h0000);
        chk("stall_addr", im_addr, 16'h0002);
        fetch(1);
        chk("stall_resume", ifid_instr, 16'h0102);

        // Redirect wins over stall on the same edge
        step(1'b0, 1'b1, 1'b1, 16'h0040);
        chk("redir_instr", ifid_instr, 16'h0000);
        fetch(1);
        chk("redir_fetch", ifid_instr, 16'h0140);

        // Halt on HALT_WORD, then stall/idle in HALTED, then redirect out
        mem[3] = 16'hFFFF;
        step(1'b0, 1'b0, 1'b1, 16'h0000);
        fetch(4);
        chk("halt_flag", {15'd0, halted}, 16'h0001);
        chk("halt_word", ifid_instr, 16'hFFFF);
        step(1'b0, 1'b1, 1'b0, 16'h0000);
        fetch(2);
        chk("halt_addr", im_addr, 16'h0003);
        step(1'b0, 1'b0, 1'b1, 16'h0000);
        fetch(1);
        chk("halt_restart", ifid_instr, 16'h0100);

        // PC wrap from FFFF
        step(1'b0, 1'b0, 1'b1, 16'hFFFF);
        fetch(1);
        chk("wrap_pc", im_addr, 16'h0000);
        chk("wrap_pc1", ifid_pc1, 16'h0000);

        // Reset while halted with redirect on the same edge
        step(1'b0, 1'b0, 1'b1, 16'h0003);
        fetch(1);
        chk("halt2_flag", {15'd0, halted}, 16'h0001);
        step(1'b1, 1'b0, 1'b1, 16'h0040);
        chk("rst_halt_count", fetch_count, 16'h0000);

        // fetch_count saturation
        mem[3] = 16'h0103;
        fetch(65540);
        chk("sat_count", fetch_count, 16'hFFFF);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
